spi_target_regs: RTL and testbench

SPI target (slave) register block: the far end of the SPI controller's serial link. It decodes the controller's frame, which is an 8-bit address phase, an idle gap and an 8-bit data phase, all LSB first. It writes into or reads from a local bank of 8-bit registers and drives `miso` for reads. It runs on the system clock, oversamples the SPI pins, and exposes a write-notify strobe and a debug read port to local logic.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_pin_sync.sv | 44 ++++
 rtl/spi_target_regs.sv | 190 +++++++++++++++++++
 tb/tb_spi_target_regs.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM encodings and frame-format constants.
package spi_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ADDR  = 5'b00010,
    S_GAP   = 5'b00100,
    S_DATA  = 5'b01000,
    S_SPARE = 5'b10000
  } spi_state_e;

  localparam int   SPI_WR_BIT     = 7;
  localparam int   SPI_GAP_CLKS   = 5;
  localparam logic SPI_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for the SPI pins plus falling-edge detect on the
// synchronized SCLK.
module spi_pin_sync #(
  parameter int               STAGES   = 2,
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               SCLK_IDX = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] pins_o,
  output logic             sclk_fall_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic             sclk_prev_q;
  logic             sclk_prev_d;

  always_comb begin
    sync_d[0] = pins_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sclk_prev_d = sync_q[STAGES-1][SCLK_IDX];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RST_VAL;
      end
      sclk_prev_q <= RST_VAL[SCLK_IDX];
    end else begin
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign pins_o      = sync_q[STAGES-1];
  assign sclk_fall_o = sclk_prev_q & ~pins_o[SCLK_IDX];

endmodule

// File: rtl/spi_target_regs.sv
// SPI target register bank: decodes address/gap/data frames (LSB first),
// writes or reads a local 8-bit register file and drives miso for reads.
module spi_target_regs
  import spi_pkg::*;
#(
  parameter int NUM_BITS    = 8,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk_i,
  input  logic       prst_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       wr_strobe_o,
  output logic [2:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic [2:0] dbg_addr_i,
  output logic [7:0] dbg_data_o,
  output logic       frame_err_o
);

  localparam int         CNT_W      = $clog2(NUM_BITS);
  localparam logic [6:0] NUM_REGS_L = 7'(NUM_REGS);

  logic [2:0] pins_s;
  logic       sclk_fall, cs_n_s, mosi_s;

  // cs_n resets to "selected" so a frame already in progress at reset release
  // cannot be joined; the bank must first see cs_n high (armed_q).
  spi_pin_sync #(
    .STAGES  (SYNC_STAGES),
    .WIDTH   (3),
    .RST_VAL (3'b001),
    .SCLK_IDX(0)
  ) u_pin_sync (
    .clk_i      (pclk_i),
    .rst_i      (prst_i),
    .pins_i     ({mosi_i, cs_n_i, sclk_i}),
    .pins_o     (pins_s),
    .sclk_fall_o(sclk_fall)
  );

  assign cs_n_s = pins_s[1];
  assign mosi_s = pins_s[2];

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_BITS-1:0] addr_sh_q, addr_sh_d;
  logic [NUM_BITS-1:0] data_sh_q, data_sh_d;
  logic [NUM_BITS-1:0] rd_sh_q, rd_sh_d;
  logic                miso_q, miso_d;
  logic                strobe_q, strobe_d;
  logic [2:0]          wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                err_q, err_d;
  logic                armed_q, armed_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];

  logic       is_wr, in_range;
  logic [2:0] idx;
  logic [7:0] commit_data;

  assign is_wr       = addr_sh_q[SPI_WR_BIT];
  assign in_range    = addr_sh_q[6:0] < NUM_REGS_L;
  assign idx         = addr_sh_q[2:0];
  assign commit_data = {mosi_s, data_sh_q[6:0]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    rd_sh_d   = rd_sh_q;
    miso_d    = miso_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    armed_d   = armed_q;
    regs_d    = regs_q;

    if (state_q != S_IDLE && cs_n_s) begin
      // Deselect beats any same-cycle SCLK edge, so a final data bit is dropped.
      state_d = S_IDLE;
      count_d = '0;
      miso_d  = SPI_IDLE_LEVEL;
      if (count_q != '0) err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          miso_d = SPI_IDLE_LEVEL;
          if (cs_n_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_ADDR;
            count_d = '0;
          end
        end
        S_ADDR: begin
          if (sclk_fall) begin
            addr_sh_d[count_q] = mosi_s;
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(NUM_BITS - 1)) begin
              state_d = S_GAP;
              if (!in_range) err_d = 1'b1;
              if (!mosi_s) begin
                rd_sh_d = in_range ? regs_q[idx] : 8'hFF;
                miso_d  = rd_sh_d[0];
              end
            end
          end
        end
        S_GAP: begin
          if (sclk_fall) begin
            state_d      = S_DATA;
            count_d      = CNT_W'(1);
            data_sh_d[0] = mosi_s;
            if (!is_wr) miso_d = rd_sh_q[1];
          end
        end
        S_DATA: begin
          if (sclk_fall) begin
            data_sh_d[count_q] = mosi_s;
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(NUM_BITS - 1)) begin
              state_d = S_ADDR;
              miso_d  = SPI_IDLE_LEVEL;
              if (is_wr && in_range) begin
                regs_d[idx] = commit_data;
                strobe_d    = 1'b1;
                wr_addr_d   = idx;
                wr_data_d   = commit_data;
              end
            end else if (!is_wr) begin
              miso_d = rd_sh_q[count_q + 1'b1];
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
          miso_d  = SPI_IDLE_LEVEL;
        end
      endcase
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      rd_sh_q   <= '0;
      miso_q    <= SPI_IDLE_LEVEL;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      rd_sh_q   <= rd_sh_d;
      miso_q    <= miso_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      regs_q    <= regs_d;
    end
  end

  assign miso_o      = miso_q;
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = err_q;
  assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: bit-bangs SPI frames and checks the
// register bank, strobes, miso and error flag against hand-computed values.
module tb_spi_target_regs;
  import spi_pkg::*;

  localparam int HALF = 8;

  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  logic       sclk = 1'b1;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso_o, wr_strobe_o, frame_err_o;
  logic [2:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data_o;

  int         checks = 0;
  int         errors = 0;
  int         strobe_cnt = 0;
  logic [2:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic [7:0] exp_regs [8];

  spi_target_regs dut (
    .pclk_i     (pclk),
    .prst_i     (prst),
    .sclk_i     (sclk),
    .cs_n_i     (cs_n),
    .mosi_i     (mosi),
    .miso_o     (miso_o),
    .wr_strobe_o(wr_strobe_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data_o),
    .frame_err_o(frame_err_o)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (wr_strobe_o === 1'b1) begin
      strobe_cnt++;
      last_addr = wr_addr_o;
      last_data = wr_data_o;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic spi_bit(input logic b, output logic sample);
    mosi = b;
    wait_cyc(HALF);
    sample = miso_o;
    sclk = 1'b0;
    wait_cyc(HALF);
    sclk = 1'b1;
  endtask

  task automatic send_addr_gap(input logic [7:0] addr);
    logic s;
    for (int i = 0; i < 8; i++) spi_bit(addr[i], s);
    wait_cyc(SPI_GAP_CLKS * 2 * HALF);
  endtask

  task automatic xfer(input logic [7:0] addr, input logic [7:0] data,
                      output logic [7:0] rd);
    logic s;
    send_addr_gap(addr);
    for (int i = 0; i < 8; i++) begin
      spi_bit(data[i], s);
      rd[i] = s;
    end
  endtask

  task automatic select();
    wait_cyc(1);
    cs_n = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic deselect();
    wait_cyc(HALF);
    cs_n = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic test_reset();
    checks++;
    if (miso_o !== 1'b1 || wr_strobe_o !== 1'b0 || frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: miso=%b strobe=%b err=%b, need 1 0 0",
               miso_o, wr_strobe_o, frame_err_o);
    end
    checks++;
    if (wr_addr_o !== 3'd0 || wr_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr_out: addr=%0d data=%h, need 0 00", wr_addr_o, wr_data_o);
    end
    checks++;
    if (dut.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %b need %b", dut.state_q, S_IDLE);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data_o !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h need 00", i, dbg_data_o);
      end
    end
  endtask

  task automatic test_write();
    logic [7:0] rd;
    int s0;
    s0 = strobe_cnt;
    select();
    xfer(8'h83, 8'hA5, rd);
    deselect();
    exp_regs[3] = 8'hA5;
    checks++;
    if (strobe_cnt - s0 != 1) begin
      errors++;
      $display("FAIL write_strobes: got %0d need 1", strobe_cnt - s0);
    end
    checks++;
    if (last_addr !== 3'd3 || last_data !== 8'hA5) begin
      errors++;
      $display("FAIL write_strobe_payload: addr=%0d data=%h need 3 a5", last_addr, last_data);
    end
    checks++;
    if (wr_addr_o !== 3'd3 || wr_data_o !== 8'hA5) begin
      errors++;
      $display("FAIL write_outputs: addr=%0d data=%h need 3 a5", wr_addr_o, wr_data_o);
    end
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data_o !== 8'hA5) begin
      errors++;
      $display("FAIL write_dbg: got %h need a5", dbg_data_o);
    end
    checks++;
    if (frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL write_err: got %b need 0", frame_err_o);
    end
  endtask

  task automatic test_read();
    logic [7:0] rd;
    int s0;
    select();
    xfer(8'h85, 8'h3C, rd);
    deselect();
    exp_regs[5] = 8'h3C;
    s0 = strobe_cnt;
    select();
    xfer(8'h05, 8'h00, rd);
    deselect();
    checks++;
    if (rd !== 8'h3C) begin
      errors++;
      $display("FAIL read_data: got %h need 3c", rd);
    end
    checks++;
    if (strobe_cnt != s0) begin
      errors++;
      $display("FAIL read_strobes: got %0d need 0", strobe_cnt - s0);
    end
    checks++;
    if (miso_o !== 1'b1) begin
      errors++;
      $display("FAIL read_miso_idle: got %b need 1", miso_o);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data_o !== exp_regs[i]) begin
        errors++;
        $display("FAIL read_regs%0d: got %h need %h", i, dbg_data_o, exp_regs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int s0;
    s0 = strobe_cnt;
    select();
    xfer(8'h80, 8'h11, rd);
    xfer(8'h81, 8'h22, rd);
    xfer(8'h01, 8'h00, rd);
    deselect();
    exp_regs[0] = 8'h11;
    exp_regs[1] = 8'h22;
    checks++;
    if (rd !== 8'h22) begin
      errors++;
      $display("FAIL b2b_read: got %h need 22", rd);
    end
    checks++;
    if (strobe_cnt - s0 != 2) begin
      errors++;
      $display("FAIL b2b_strobes: got %0d need 2", strobe_cnt - s0);
    end
    for (int i = 0; i < 2; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data_o !== exp_regs[i]) begin
        errors++;
        $display("FAIL b2b_reg%0d: got %h need %h", i, dbg_data_o, exp_regs[i]);
      end
    end
    checks++;
    if (frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err: got %b need 0", frame_err_o);
    end
  endtask

  task automatic test_abort();
    logic s;
    int s0;
    s0 = strobe_cnt;
    select();
    send_addr_gap(8'h82);
    spi_bit(1'b1, s);
    spi_bit(1'b0, s);
    spi_bit(1'b1, s);
    spi_bit(1'b0, s);
    wait_cyc(2);
    cs_n = 1'b1;
    wait_cyc(HALF);
    dbg_addr = 3'd2;
    #1;
    checks++;
    if (dbg_data_o !== exp_regs[2]) begin
      errors++;
      $display("FAIL abort_reg2: got %h need %h", dbg_data_o, exp_regs[2]);
    end
    checks++;
    if (strobe_cnt != s0) begin
      errors++;
      $display("FAIL abort_strobes: got %0d need 0", strobe_cnt - s0);
    end
    checks++;
    if (frame_err_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_err: got %b need 1", frame_err_o);
    end
    checks++;
    if (dut.state_q !== S_IDLE || miso_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: state=%b miso=%b need %b 1", dut.state_q, miso_o, S_IDLE);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic s;
    select();
    send_addr_gap(8'h84);
    spi_bit(1'b1, s);
    spi_bit(1'b1, s);
    spi_bit(1'b1, s);
    #2;
    prst = 1'b1;
    #1;
    checks++;
    if (miso_o !== 1'b1 || wr_strobe_o !== 1'b0 || frame_err_o !== 1'b0 ||
        wr_addr_o !== 3'd0 || wr_data_o !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs: miso=%b strobe=%b err=%b addr=%0d data=%h need 1 0 0 0 00",
               miso_o, wr_strobe_o, frame_err_o, wr_addr_o, wr_data_o);
    end
    for (int i = 0; i < 8; i++) begin
      exp_regs[i] = 8'h00;
      dbg_addr = 3'(i);
      #0.1;
      checks++;
      if (dbg_data_o !== 8'h00) begin
        errors++;
        $display("FAIL midrst_reg%0d: got %h need 00", i, dbg_data_o);
      end
    end
    wait_cyc(3);
    prst = 1'b0;
    // cs_n still low: the bank must stay idle until it sees a fresh select
    repeat (4) spi_bit(1'b1, s);
    checks++;
    if (dut.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL midrst_no_rejoin: state=%b need %b", dut.state_q, S_IDLE);
    end
    cs_n = 1'b1;
    wait_cyc(HALF);
    test_write();
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd;
    int s0;
    s0 = strobe_cnt;
    checks++;
    if (frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_err_before: got %b need 0", frame_err_o);
    end
    select();
    xfer(8'h8A, 8'hFF, rd);
    deselect();
    checks++;
    if (strobe_cnt != s0) begin
      errors++;
      $display("FAIL oor_strobes: got %0d need 0", strobe_cnt - s0);
    end
    checks++;
    if (frame_err_o !== 1'b1) begin
      errors++;
      $display("FAIL oor_err: got %b need 1", frame_err_o);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data_o !== exp_regs[i]) begin
        errors++;
        $display("FAIL oor_reg%0d: got %h need %h", i, dbg_data_o, exp_regs[i]);
      end
    end
    select();
    xfer(8'h0A, 8'h00, rd);
    deselect();
    checks++;
    if (rd !== 8'hFF) begin
      errors++;
      $display("FAIL oor_read: got %h need ff", rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    wait_cyc(3);
    test_reset();
    prst = 1'b0;
    wait_cyc(6);
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
